// File: rtl/mac_accumulator.sv
// ----------------------------------------------------------------------------
// mac_accumulator
//
// Streaming signed multiply-accumulate stage. Computes the dot product of two
// fixed-point operand vectors whose length is given at run time, and presents
// one wide accumulator result per vector. The result carries 2*FRAC_W
// fractional bits and is consumed by the downstream Quantizer unmodified.
//
// Element pipeline: an accepted pair is multiplied into the product register
// on the accepting edge and added into the accumulator on the following edge.
//
// Optional build macro:
//   MAC_SATURATE_EN  defined   -> accumulator clamps to the signed limits on
//                                 overflow
//                    undefined -> accumulator wraps modulo 2^ACC_W
//   The overflow flag behaves identically in both builds.
//
// Parameters:
//   DATA_W  operand width, signed two's complement
//   FRAC_W  fractional bits per operand
//   ACC_W   accumulator / result width (ACC_W >= 2*DATA_W)
//   LEN_W   width of the vector-length field
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      begin a vector (sampled only when idle)
//   vec_len    element count, latched on an accepted start
//   in_valid   operand pair valid
//   in_ready   block accepts an operand pair
//   a, b       signed operands
//   out_valid  acc_out holds a finished result
//   out_ready  downstream accepts the result
//   acc_out    signed dot-product result
//   overflow   sticky: accumulator overflowed during the current vector
//   busy       high whenever the block is not idle
// ----------------------------------------------------------------------------
module mac_accumulator #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow,
  output logic              busy
);

  localparam int PROD_W = 2 * DATA_W;

  // Reject parameter sets where the product would not fit the accumulator or
  // the operand would have no integer/sign bit left.
  if (ACC_W < PROD_W || FRAC_W >= DATA_W) begin : g_param_check
    $error("mac_accumulator: illegal DATA_W/FRAC_W/ACC_W combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state, state_next;

  logic                     accept;
  logic                     start_go;
  logic [LEN_W-1:0]         remaining;
  logic                     prod_vld;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [PROD_W-1:0] a_ext, b_ext;
  logic signed [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         sum;
  logic [ACC_W-1:0]         acc_next;
  logic                     add_ovf;

  assign accept   = in_valid & in_ready;
  assign start_go = (state == IDLE) && start;

  // Operands widened to the product width so the multiply is exact and
  // free of any context-width surprises.
  assign a_ext = PROD_W'($signed(a));
  assign b_ext = PROD_W'($signed(b));

  assign prod_ext = ACC_W'(prod_q);
  assign sum      = acc + prod_ext;

  // Signed overflow: both addends share a sign and the sum's sign differs.
  assign add_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef MAC_SATURATE_EN
  // Clamp toward the sign of the addends; later adds proceed from the limit.
  always_comb begin
    acc_next = sum;
    if (add_ovf) begin
      acc_next = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                              : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign acc_next = sum;
`endif

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  // NOTE: all state here updates with non-blocking assignments so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      prod_q    <= '0;
      prod_vld  <= 1'b0;
      remaining <= '0;
      overflow  <= 1'b0;
    end else begin
      state    <= state_next;
      prod_vld <= accept;

      if (accept) begin
        prod_q <= a_ext * b_ext;
      end

      if (start_go) begin
        remaining <= vec_len;
      end else if (accept) begin
        remaining <= remaining - LEN_W'(1);
      end

      if (start_go) begin
        acc      <= '0;
        overflow <= 1'b0;
      end else if (prod_vld) begin
        acc <= acc_next;
        if (add_ovf) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (vec_len != '0) ? ACCUM : HOLD;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && remaining == LEN_W'(1)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // The final product is folded in on the edge where prod_vld is high.
        if (!prod_vld) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign acc_out = acc;

endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  vec_len;
  logic        in_valid;
  logic [7:0]  a, b;
  logic        out_ready;

  logic        in_ready, out_valid, overflow, busy;
  logic [23:0] acc_out;
  logic        in_ready16, out_valid16, overflow16, busy16;
  logic [15:0] acc16;

  int tests = 0;
  int fails = 0;

  // Expected narrow-accumulator result for 3 x (0x7F * 0x7F) = 48387.
`ifdef MAC_SATURATE_EN
  localparam logic [15:0] OVF16_EXP = 16'h7FFF;
`else
  localparam logic [15:0] OVF16_EXP = 16'hBD03;
`endif

  always #5 clk = ~clk;

  mac_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .overflow(overflow), .busy(busy)
  );

  mac_accumulator #(.ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_ready(in_ready16), .a(a), .b(b),
    .out_valid(out_valid16), .out_ready(out_ready), .acc_out(acc16),
    .overflow(overflow16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_vec(input logic [7:0] len);
    start   = 1'b1;
    vec_len = len;
    tick();
    start   = 1'b0;
  endtask

  task automatic feed(input logic [7:0] va, input logic [7:0] vb, input int gap);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " out_valid16"}, out_valid16, 1);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " idle after take"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; vec_len = '0; in_valid = 1'b0;
    a = '0; b = '0; out_ready = 1'b0;
    #1;
    tick();
    tick();
    check("reset acc_out",   acc_out,   0);
    check("reset out_valid", out_valid, 0);
    check("reset in_ready",  in_ready,  0);
    check("reset overflow",  overflow,  0);
    check("reset busy",      busy,      0);
    rst_n = 1'b1;
    tick();

    // Basic dot product: 4 x (1.5 * 2.0) = 12.0 -> 0x000C00.
    start_vec(8'd4);
    check("basic busy", busy, 1);
    check("basic in_ready", in_ready, 1);
    in_valid = 1'b1; a = 8'h18; b = 8'h20;
    repeat (3) tick();
    check("basic in_ready before last", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("basic in_ready after last", in_ready, 0);
    check("basic out_valid t", out_valid, 0);
    tick();
    check("basic out_valid t+1", out_valid, 0);
    tick();
    check("basic out_valid t+2", out_valid, 1);
    check("basic acc_out", acc_out, 32'h000C00);
    check("basic acc16", acc16, 32'h0C00);
    check("basic overflow", overflow, 0);
    handshake("basic");

    // Negative operands with 2-cycle bubbles: 3 x (-1.0 * 0.5) = -384.
    start_vec(8'd3);
    feed(8'hF0, 8'h08, 2);
    feed(8'hF0, 8'h08, 2);
    feed(8'hF0, 8'h08, 2);
    wait_out("neg");
    check("neg acc_out", acc_out, 32'hFFFE80);
    check("neg acc16", acc16, 32'hFE80);
    check("neg overflow", overflow, 0);
    handshake("neg");

    // Overflow: 3 x (0x7F * 0x7F) = 48387 fits 24 bits, overflows 16 bits.
    start_vec(8'd3);
    in_valid = 1'b1; a = 8'h7F; b = 8'h7F;
    repeat (3) tick();
    in_valid = 1'b0;
    wait_out("ovf");
    check("ovf acc_out 24b", acc_out, 32'h00BD03);
    check("ovf overflow 24b", overflow, 0);
    check("ovf acc16", acc16, OVF16_EXP);
    check("ovf overflow16", overflow16, 1);
    handshake("ovf");

    // Backpressure with an ignored start: result 2 x (1.0 * 1.0) = 0x200.
    start_vec(8'd2);
    check("overflow16 cleared by start", overflow16, 0);
    in_valid = 1'b1; a = 8'h10; b = 8'h10;
    repeat (2) tick();
    in_valid = 1'b0;
    wait_out("bp");
    for (int i = 0; i < 5; i++) begin
      start   = (i == 2);
      vec_len = 8'd5;
      tick();
      check("bp acc_out stable", acc_out, 32'h000200);
      check("bp in_ready low", in_ready, 0);
      check("bp out_valid held", out_valid, 1);
    end
    start = 1'b0;
    handshake("bp");
    check("bp start ignored in_ready", in_ready, 0);

    // Zero-length vector: result is ready the next cycle, nothing accepted.
    in_valid = 1'b1; a = 8'h7F; b = 8'h7F;
    start_vec(8'd0);
    check("zero out_valid", out_valid, 1);
    check("zero acc_out", acc_out, 0);
    check("zero in_ready", in_ready, 0);
    in_valid = 1'b0;
    handshake("zero");

    // Reset mid-vector, then a fresh 1-element vector: 1.0 * 1.0 = 0x000100.
    start_vec(8'd4);
    feed(8'h40, 8'h40, 0);
    feed(8'h40, 8'h40, 0);
    rst_n = 1'b0;
    tick();
    check("midrst acc_out",   acc_out,   0);
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready",  in_ready,  0);
    check("midrst overflow",  overflow,  0);
    check("midrst busy",      busy,      0);
    check("midrst acc16",     acc16,     0);
    rst_n = 1'b1;
    start_vec(8'd1);
    feed(8'h10, 8'h10, 0);
    wait_out("fresh");
    check("fresh acc_out", acc_out, 32'h000100);
    check("fresh acc16", acc16, 32'h0100);
    handshake("fresh");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
